spi_reg_responder: RTL

- SPI responder (slave) for the SPI master on the sensor bus (SEN_SPC/SEN_SDI/SEN_SDO/SEN_CS).
- Emulates the accelerometer's register protocol: 64 x 8 register map, mode 3, address byte plus data bytes.
- Used as an on-board sensor stand-in and as the bench model for the sequencer/master pair.
- Runs entirely in the CLK12M domain; SPI pins are oversampled.

---
 rtl/spi_reg_responder_if.sv | 10 +
 rtl/spi_reg_responder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_responder_if.sv
// SPI pin bundle between the sensor-bus master and the register responder.
interface spi_reg_responder_if;
    logic spi_sck;
    logic spi_mosi;
    logic spi_csn;
    logic spi_miso;

    modport master (output spi_sck, output spi_mosi, output spi_csn, input spi_miso);
    modport slave  (input spi_sck, input spi_mosi, input spi_csn, output spi_miso);
endinterface

// File: rtl/spi_reg_responder.sv
// SPI mode-3 responder emulating a 64x8 accelerometer register map, oversampled in CLK12M.
// Define SPI_RESP_TRISTATE_EN to float spi_miso outside the data phase.
module spi_reg_responder #(
    parameter logic [7:0] WHO_AM_I_VAL = 8'h33,
    parameter logic [5:0] SAMPLE_BASE  = 6'h28
) (
    input  logic                  CLK12M,
    input  logic                  nrst,
    spi_reg_responder_if.slave    spi,
    input  logic [47:0]           sample_in,
    output logic                  wr_strobe,
    output logic [5:0]            wr_addr,
    output logic [7:0]            wr_data,
    output logic                  busy
);

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    state_e      state_q, state_d;
    logic [1:0]  sck_sync, mosi_sync, csn_sync;
    logic        sck_prev, csn_prev;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  sh_q, sh_d;
    logic [5:0]  addr_q, addr_d;
    logic        rw_q, rw_d, ms_q, ms_d;
    logic        miso_q, miso_d;
    logic        strobe_q, strobe_d;
    logic [5:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic [7:0]  regs_q [64];
    logic [7:0]  samp_q [6];
    logic        reg_we, snap;
    logic [7:0]  byte_in, rd_data;
    logic [5:0]  samp_off;
    logic        in_samp;
    logic        sck_rise, sck_fall, csn_rise, csn_fall;

    always_ff @(posedge CLK12M or negedge nrst) begin
        if (!nrst) begin
            sck_sync  <= 2'b11;
            mosi_sync <= 2'b00;
            csn_sync  <= 2'b11;
            sck_prev  <= 1'b1;
            csn_prev  <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[0], spi.spi_sck};
            mosi_sync <= {mosi_sync[0], spi.spi_mosi};
            csn_sync  <= {csn_sync[0], spi.spi_csn};
            sck_prev  <= sck_sync[1];
            csn_prev  <= csn_sync[1];
        end
    end

    assign sck_rise = sck_sync[1] & ~sck_prev;
    assign sck_fall = ~sck_sync[1] & sck_prev;
    assign csn_rise = csn_sync[1] & ~csn_prev;
    assign csn_fall = ~csn_sync[1] & csn_prev;
    assign byte_in  = {sh_q[6:0], mosi_sync[1]};

    // Modulo-64 offset keeps the range test correct for any SAMPLE_BASE.
    assign samp_off = addr_q - SAMPLE_BASE;
    assign in_samp  = (samp_off < 6'd6);

    always_comb begin
        rd_data = regs_q[addr_q];
        if (in_samp) rd_data = samp_q[samp_off[2:0]];
        if (addr_q == 6'h0F) rd_data = WHO_AM_I_VAL;
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sh_d      = sh_q;
        addr_d    = addr_q;
        rw_d      = rw_q;
        ms_d      = ms_q;
        miso_d    = miso_q;
        strobe_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        reg_we    = 1'b0;
        snap      = 1'b0;
        unique case (state_q)
            StIdle: begin
                miso_d = 1'b0;
                if (csn_fall) begin
                    state_d   = StAddr;
                    bit_cnt_d = 3'd0;
                    snap      = 1'b1;
                end
            end
            StAddr: begin
                miso_d = 1'b0;
                if (csn_rise) begin
                    state_d = StIdle;
                end else if (sck_rise) begin
                    sh_d      = byte_in;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rw_d    = byte_in[7];
                        ms_d    = byte_in[6];
                        addr_d  = byte_in[5:0];
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (csn_rise) begin
                    state_d = StIdle;
                    miso_d  = 1'b0;
                end else if (rw_q) begin
                    // bit_cnt counts rising edges, so a fall with zero count opens a new byte.
                    if (sck_fall) begin
                        if (bit_cnt_q == 3'd0) begin
                            miso_d = rd_data[7];
                            sh_d   = {rd_data[6:0], 1'b0};
                            if (ms_q) addr_d = addr_q + 6'd1;
                        end else begin
                            miso_d = sh_q[7];
                            sh_d   = {sh_q[6:0], 1'b0};
                        end
                    end
                    if (sck_rise) bit_cnt_d = bit_cnt_q + 3'd1;
                end else if (sck_rise) begin
                    sh_d      = byte_in;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        strobe_d  = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = byte_in;
                        reg_we    = (addr_q != 6'h0F) && !in_samp;
                        if (ms_q) addr_d = addr_q + 6'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK12M or negedge nrst) begin
        if (!nrst) begin
            state_q   <= StIdle;
            bit_cnt_q <= 3'd0;
            sh_q      <= 8'd0;
            addr_q    <= 6'd0;
            rw_q      <= 1'b0;
            ms_q      <= 1'b0;
            miso_q    <= 1'b0;
            strobe_q  <= 1'b0;
            wr_addr_q <= 6'd0;
            wr_data_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            sh_q      <= sh_d;
            addr_q    <= addr_d;
            rw_q      <= rw_d;
            ms_q      <= ms_d;
            miso_q    <= miso_d;
            strobe_q  <= strobe_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_ff @(posedge CLK12M or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < 64; i++) regs_q[i] <= 8'd0;
            for (int k = 0; k < 6; k++) samp_q[k] <= 8'd0;
        end else begin
            if (reg_we) regs_q[addr_q] <= byte_in;
            if (snap) begin
                for (int k = 0; k < 6; k++) samp_q[k] <= sample_in[8*k +: 8];
            end
        end
    end

    assign wr_strobe = strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = (state_q != StIdle);

`ifdef SPI_RESP_TRISTATE_EN
    assign spi.spi_miso = (state_q == StData) ? miso_q : 1'bz;
`else
    assign spi.spi_miso = miso_q;
`endif

endmodule
